// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce filter: FSM state encoding and
// the default qualification length.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'b00,
    RISE_CHK = 2'b01,
    HIGH     = 2'b10,
    FALL_CHK = 2'b11
  } state_e;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear on
// the asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  // No logic between the flops so the first stage has a full cycle to resolve.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule : sync_2ff

// File: rtl/debounce_filter.sv
// Debounce filter: synchronizes d_raw and accepts a new level only after
// STABLE_CYCLES equal samples. Optional rise/fall pulses under DEBOUNCE_EDGE_EN.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
`ifdef DEBOUNCE_EDGE_EN
  output logic rise,
  output logic fall,
`endif
  output logic q
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d_raw),
    .q   (s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  // Any disagreeing sample during a check state drops straight back to the
  // settled state, so qualification always restarts from scratch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      LOW: begin
        if (s) begin
          state_d = RISE_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      RISE_CHK: begin
        if (!s) begin
          state_d = LOW;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = FALL_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      FALL_CHK: begin
        if (s) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = LOW;
    endcase
  end

  // Decoding the next state keeps q registered yet aligned with the state.
  assign q_d = (state_d == HIGH) || (state_d == FALL_CHK);
  assign q   = q_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  assign rise_d = (state_q == RISE_CHK) && (state_d == HIGH);
  assign fall_d = (state_q == FALL_CHK) && (state_d == LOW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule : debounce_filter

// File: tb/tb_debounce_filter.sv
// Self-checking bench for debounce_filter (STABLE_CYCLES=4, 10 ns clock);
// rise/fall are checked when DEBOUNCE_EDGE_EN is defined.
module tb_debounce_filter;

  typedef struct {
    logic  d;
    logic  q;
    logic  r;
    logic  f;
    string nm;
  } vec_t;

  typedef struct {
    logic  q;
    logic  r;
    logic  f;
    string nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic d_raw;
  logic q;
  logic rise;
  logic fall;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];
  exp_t sb[$];

  debounce_filter #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .d_raw (d_raw),
`ifdef DEBOUNCE_EDGE_EN
    .rise  (rise),
    .fall  (fall),
`endif
    .q     (q)
  );

`ifndef DEBOUNCE_EDGE_EN
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string nm, input logic eq, input logic er, input logic ef);
    chk({nm, ".q"}, q, eq);
`ifdef DEBOUNCE_EDGE_EN
    chk({nm, ".rise"}, rise, er);
    chk({nm, ".fall"}, fall, ef);
`endif
  endtask

  task automatic add(input logic d, input logic eq, input logic er, input logic ef,
                     input int n, input string nm);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.d = d; v.q = eq; v.r = er; v.f = ef; v.nm = nm;
      vecs.push_back(v);
    end
  endtask

  // Called at a falling edge: drive, queue expectation, compare after next rising edge.
  task automatic step(input logic d, input logic eq, input logic er, input logic ef,
                      input string nm);
    exp_t e;
    exp_t got;
    d_raw = d;
    e.q = eq; e.r = er; e.f = ef; e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk_outs(got.nm, got.q, got.r, got.f);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Stimulus tables for the contiguous part of the run.
    add(0, 0, 0, 0, 3, "idle");
    add(1, 0, 0, 0, 5, "rise_wait");
    add(1, 1, 1, 0, 1, "rise_edge");
    add(1, 1, 0, 0, 2, "rise_hold");
    add(0, 1, 0, 0, 5, "fall_wait");
    add(0, 0, 0, 1, 1, "fall_edge");
    add(0, 0, 0, 0, 2, "fall_hold");
    add(1, 0, 0, 0, 3, "glitch_hi");
    add(0, 0, 0, 0, 6, "glitch_lo");
    add(1, 0, 0, 0, 1, "bounce_b0");
    add(0, 0, 0, 0, 1, "bounce_b1");
    add(1, 0, 0, 0, 5, "bounce_wait");
    add(1, 1, 1, 0, 1, "bounce_edge");
    add(1, 1, 0, 0, 1, "bounce_hold");

    // Reset held with d_raw=1: outputs stay low, including between edges.
    rst   = 1'b0;
    d_raw = 1'b1;
    #1  chk_outs("rst_t1", 0, 0, 0);
    #6  chk_outs("rst_t7", 0, 0, 0);
    #7  chk_outs("rst_t14", 0, 0, 0);
    #8  chk_outs("rst_t22", 0, 0, 0);
    #7  chk_outs("rst_t29", 0, 0, 0);
    @(negedge clk);
    d_raw = 1'b0;
    rst   = 1'b1;

    foreach (vecs[i]) step(vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].f, vecs[i].nm);

    // Asynchronous reset between edges while HIGH.
    #2 rst = 1'b0;
    #1 chk_outs("async_rst_high", 0, 0, 0);
    @(posedge clk);
    #1 chk_outs("rst_held_edge", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "post_rst_idle");

    // Get into RISE_CHK with cnt=2, then reset.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, "pre_midrst");
    #2 rst = 1'b0;
    #1 chk_outs("midrst_q", 0, 0, 0);
    @(posedge clk);
    #1 chk_outs("midrst_edge", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, "midrst_wait");
    step(1, 1, 1, 0, "midrst_edge_rise");
    step(1, 1, 0, 0, "midrst_hold");

    chk("sb_empty", (sb.size() == 0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_debounce_filter
